// File: rtl/inst_encoder_writer.sv
`default_nettype none
// ============================================================================
// Module   : inst_encoder_writer
// Brief    : Packs decoded RV32I fields into instruction words and streams
//            them into instruction memory through a bounded write pointer.
// Revision : 1.0
// ============================================================================
module inst_encoder_writer #(
    parameter int DEPTH  = 64,
    parameter int BASE   = 0,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_im,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm32,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [CNT_W-1:0]  inst_count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [2:0] c_fmt_r = 3'd0;
    localparam logic [2:0] c_fmt_i = 3'd1;
    localparam logic [2:0] c_fmt_s = 3'd2;
    localparam logic [2:0] c_fmt_b = 3'd3;
    localparam logic [2:0] c_fmt_u = 3'd4;
    localparam logic [2:0] c_fmt_j = 3'd5;

    localparam logic [1:0] c_err_none = 2'd0;
    localparam logic [1:0] c_err_imm  = 2'd1;
    localparam logic [1:0] c_err_fmt  = 2'd2;

    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_enc_vld;
    logic              r_enc_ok;
    logic [1:0]        r_enc_code;
    logic [31:0]       r_enc_word;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic [31:0]       w_word;
    logic              w_ok;
    logic [1:0]        w_code;
    logic              w_sx11;
    logic              w_sx12;
    logic              w_sx20;
    logic              w_write;
    logic              w_ready;
    logic              w_accept;
    logic [CNT_W:0]    w_committed;

    // Immediate range checks: upper bits must be a pure sign extension.
    assign w_sx11 = (&imm32[31:11]) | ~(|imm32[31:11]);
    assign w_sx12 = (&imm32[31:12]) | ~(|imm32[31:12]);
    assign w_sx20 = (&imm32[31:20]) | ~(|imm32[31:20]);

    always_comb begin
        w_word = '0;
        w_ok   = 1'b1;
        w_code = c_err_none;
        case (fmt)
            c_fmt_r: w_word = {funct7, rs2, rs1, funct3, rd, opcode};
            c_fmt_i: begin
                w_word = {imm32[11:0], rs1, funct3, rd, opcode};
                w_ok   = w_sx11;
            end
            c_fmt_s: begin
                w_word = {imm32[11:5], rs2, rs1, funct3, imm32[4:0], opcode};
                w_ok   = w_sx11;
            end
            c_fmt_b: begin
                w_word = {imm32[12], imm32[10:5], rs2, rs1, funct3,
                          imm32[4:1], imm32[11], opcode};
                w_ok   = w_sx12 & ~imm32[0];
            end
            c_fmt_u: begin
                w_word = {imm32[31:12], rd, opcode};
                w_ok   = ~(|imm32[11:0]);
            end
            c_fmt_j: begin
                w_word = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], rd, opcode};
                w_ok   = w_sx20 & ~imm32[0];
            end
            default: begin
                w_ok   = 1'b0;
                w_code = c_err_fmt;
            end
        endcase
        if (!w_ok && (w_code == c_err_none)) begin
            w_code = c_err_imm;
        end
    end

    // A good word already in the stage register has claimed a slot.
    assign w_committed = {1'b0, r_count} + {{CNT_W{1'b0}}, r_enc_vld & r_enc_ok};
    assign w_ready     = !rst && !clr && (w_committed < (CNT_W + 1)'(DEPTH));
    assign w_accept    = in_valid && w_ready;
    assign w_write     = r_enc_vld && r_enc_ok && !rst && !clr;

    always_ff @(posedge clk_im) begin
        if (rst || clr) begin
            r_ptr      <= ADDR_W'(BASE);
            r_count    <= '0;
            r_full     <= 1'b0;
            r_enc_vld  <= 1'b0;
            r_enc_ok   <= 1'b0;
            r_enc_code <= c_err_none;
            r_enc_word <= '0;
            r_err      <= 1'b0;
            r_err_code <= c_err_none;
        end else begin
            if (w_write) begin
                r_ptr   <= r_ptr + ADDR_W'(4);
                r_count <= r_count + CNT_W'(1);
                r_full  <= (r_count + CNT_W'(1)) == CNT_W'(DEPTH);
            end
            if (r_enc_vld && !r_enc_ok && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= r_enc_code;
            end
            r_enc_vld <= w_accept;
            if (w_accept) begin
                r_enc_ok   <= w_ok;
                r_enc_code <= w_code;
                // Rejected bundles leave the last good word on im_wdata.
                if (w_ok) begin
                    r_enc_word <= w_word;
                end
            end
        end
    end

    assign in_ready   = w_ready;
    assign im_we      = w_write;
    assign im_addr    = r_ptr;
    assign im_wdata   = r_enc_word;
    assign inst_count = r_count;
    assign full       = r_full;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_encoder_writer
// Brief    : Self-checking bench for inst_encoder_writer with a field-level
//            reference model of encoding, capacity and error latching.
// Revision : 1.0
// ============================================================================
module tb_inst_encoder_writer;

    localparam int DEPTH  = 4;
    localparam int BASE   = 32'h100;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } bundle_t;

    logic              clk_im = 1'b0;
    logic              rst = 1'b1, clr = 1'b0, in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        fmt = '0;
    logic [6:0]        opcode = '0, funct7 = '0;
    logic [2:0]        funct3 = '0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]       imm32 = '0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [CNT_W-1:0]  inst_count;
    logic              full, err;
    logic [1:0]        err_code;

    inst_encoder_writer #(.DEPTH(DEPTH), .BASE(BASE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_im(clk_im), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm32(imm32),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .inst_count(inst_count), .full(full), .err(err), .err_code(err_code)
    );

    always #5 clk_im = ~clk_im;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: words written, pending stage contents, error latch.
    int          m_cnt = 0;
    bit          m_pv = 0, m_pok = 0, m_err = 0;
    int          m_pcode = 0, m_code = 0;
    logic [31:0] m_wdata = '0;

    // Pre-edge snapshot of DUT outputs and model expectations.
    logic        obs_ready, obs_we, exp_ready, exp_we;
    logic [31:0] obs_addr, obs_wdata, exp_addr, exp_wdata;

    function automatic bundle_t mk(input int f, input int op, input int f3, input int f7,
                                   input int d, input int s1, input int s2, input logic [31:0] imm);
        bundle_t b;
        b.fmt = 3'(f); b.op = 7'(op); b.f3 = 3'(f3); b.f7 = 7'(f7);
        b.rd = 5'(d); b.rs1 = 5'(s1); b.rs2 = 5'(s2); b.imm = imm;
        return b;
    endfunction

    function automatic int ref_code(input bundle_t b);
        longint s;
        s = longint'($signed(b.imm));
        case (b.fmt)
            3'd0:       return 0;
            3'd1, 3'd2: return (s >= -2048 && s <= 2047) ? 0 : 1;
            3'd3:       return (s % 2 == 0 && s >= -4096 && s <= 4095) ? 0 : 1;
            3'd4:       return (b.imm % 4096 == 0) ? 0 : 1;
            3'd5:       return (s % 2 == 0 && s >= -(64'sd1 << 20) && s < (64'sd1 << 20)) ? 0 : 1;
            default:    return 2;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input bundle_t b);
        logic [31:0] u, op, f3, f7, d, s1, s2;
        u = b.imm; op = 32'(b.op); f3 = 32'(b.f3); f7 = 32'(b.f7);
        d = 32'(b.rd); s1 = 32'(b.rs1); s2 = 32'(b.rs2);
        case (b.fmt)
            3'd0: return (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            3'd1: return ((u & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            3'd2: return (((u >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                         | ((u & 32'h1F) << 7) | op;
            3'd3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (s2 << 20)
                         | (s1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                         | (((u >> 11) & 1) << 7) | op;
            3'd4: return (u & 32'hFFFFF000) | (d << 7) | op;
            3'd5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                         | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (d << 7) | op;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bundle_t rand_bundle(input bit legal_only);
        bundle_t b;
        logic [31:0] r;
        logic [11:0] t12;
        logic [12:0] t13;
        logic [20:0] t21;
        b = bundle_t'({$urandom, $urandom, $urandom});
        b.fmt = 3'($urandom_range(0, 5));
        if (!legal_only && $urandom_range(0, 7) == 0) b.fmt = 3'($urandom_range(6, 7));
        r = $urandom; t12 = 12'(r); t13 = 13'(r) & ~13'd1; t21 = 21'(r) & ~21'd1;
        case (b.fmt)
            3'd1, 3'd2: b.imm = {{20{t12[11]}}, t12};
            3'd3:       b.imm = {{19{t13[12]}}, t13};
            3'd4:       b.imm = r & 32'hFFFFF000;
            3'd5:       b.imm = {{11{t21[20]}}, t21};
            default:    b.imm = r;
        endcase
        if (!legal_only && $urandom_range(0, 4) == 0) b.imm = $urandom;
        return b;
    endfunction

    // One clock cycle: drive, snapshot outputs and expectations, clock, advance model.
    task automatic tick(input bit v, input bundle_t b, input bit c, input bit r);
        bit acc;
        int code;
        in_valid = v; fmt = b.fmt; opcode = b.op; funct3 = b.f3; funct7 = b.f7;
        rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; imm32 = b.imm; clr = c; rst = r;
        #1;
        obs_ready = in_ready; obs_we = im_we; obs_addr = im_addr; obs_wdata = im_wdata;
        exp_ready = !c && !r && (m_cnt + int'(m_pv && m_pok)) < DEPTH;
        exp_we    = m_pv && m_pok && !c && !r;
        exp_addr  = 32'(BASE + 4 * m_cnt);
        exp_wdata = m_wdata;
        acc = v && exp_ready;
        @(posedge clk_im);
        if (c || r) begin
            m_cnt = 0; m_pv = 0; m_pok = 0; m_err = 0; m_code = 0; m_wdata = '0;
        end else begin
            if (m_pv && m_pok) m_cnt++;
            if (m_pv && !m_pok && !m_err) begin m_err = 1; m_code = m_pcode; end
            m_pv = acc;
            if (acc) begin
                code = ref_code(b);
                m_pok = (code == 0); m_pcode = code;
                if (m_pok) m_wdata = ref_word(b);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(0, '0, 0, 0);
        n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", obs_ready); end
        n_checks++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", obs_we); end
        n_checks++; if (obs_addr !== 32'(BASE)) begin n_fail++; $display("FAIL reset_addr: got %h want %h", obs_addr, BASE); end
        n_checks++; if (obs_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", obs_wdata); end
        n_checks++; if (inst_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", inst_count); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", err_code); end
    endtask

    task automatic test_r_i_type();
        tick(1, mk(0, 'h33, 0, 0, 3, 1, 2, 0), 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL add_we: got %b want 1", obs_we); end
        n_checks++; if (obs_addr !== 32'(BASE)) begin n_fail++; $display("FAIL add_addr: got %h want %h", obs_addr, BASE); end
        n_checks++; if (obs_wdata !== 32'h002081B3) begin n_fail++; $display("FAIL add_data: got %h want 002081b3", obs_wdata); end
        n_checks++; if (inst_count !== 3'd1) begin n_fail++; $display("FAIL add_count: got %0d want 1", inst_count); end
        tick(1, mk(1, 'h13, 0, 0, 1, 0, 0, 32'hFFFFFFFF), 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b1 || obs_wdata !== 32'hFFF00093) begin n_fail++; $display("FAIL addi_data: got we=%b %h want we=1 fff00093", obs_we, obs_wdata); end
        n_checks++; if (obs_addr !== 32'(BASE + 4)) begin n_fail++; $display("FAIL addi_addr: got %h want %h", obs_addr, BASE + 4); end
        tick(1, mk(1, 'h13, 0, 0, 1, 0, 0, 32'h800), 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL badimm_we: got %b want 0", obs_we); end
        n_checks++; if (err !== 1'b1 || err_code !== 2'd1) begin n_fail++; $display("FAIL badimm_err: got err=%b code=%0d want 1/1", err, err_code); end
        n_checks++; if (im_addr !== 32'(BASE + 8)) begin n_fail++; $display("FAIL badimm_ptr: got %h want %h", im_addr, BASE + 8); end
        tick(0, '0, 1, 0);
    endtask

    task automatic test_branch_jump();
        tick(1, mk(3, 'h63, 0, 0, 0, 1, 2, 8), 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b1 || obs_wdata !== 32'h00208463) begin n_fail++; $display("FAIL beq_data: got we=%b %h want we=1 00208463", obs_we, obs_wdata); end
        tick(1, mk(3, 'h63, 0, 0, 0, 1, 2, 7), 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b0 || err_code !== 2'd1) begin n_fail++; $display("FAIL b_odd: got we=%b code=%0d want 0/1", obs_we, err_code); end
        tick(1, mk(5, 'h6F, 0, 0, 1, 0, 0, 32'h800), 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b1 || obs_wdata !== 32'h001000EF) begin n_fail++; $display("FAIL jal_data: got we=%b %h want we=1 001000ef", obs_we, obs_wdata); end
        tick(1, mk(4, 'h37, 0, 0, 5, 0, 0, 32'h12345000), 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b1 || obs_wdata !== 32'h123452B7) begin n_fail++; $display("FAIL lui_data: got we=%b %h want we=1 123452b7", obs_we, obs_wdata); end
        n_checks++; if (obs_addr !== 32'(BASE + 8)) begin n_fail++; $display("FAIL lui_addr: got %h want %h", obs_addr, BASE + 8); end
        tick(0, '0, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[8];
        int nw = 0;
        for (int k = 0; k < 8; k++) begin
            bundle_t b = rand_bundle(1);
            words[k] = ref_word(b);
            tick(k < 6, b, 0, 0);
            n_checks++; if (obs_ready !== (k < 4)) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, obs_ready, k < 4); end
            n_checks++; if (obs_we !== (k >= 1 && k <= 4)) begin n_fail++; $display("FAIL b2b_we[%0d]: got %b want %b", k, obs_we, k >= 1 && k <= 4); end
            if (obs_we) begin
                n_checks++; if (obs_addr !== 32'(BASE + 4 * nw) || obs_wdata !== words[k-1]) begin
                    n_fail++; $display("FAIL b2b_write[%0d]: got %h:%h want %h:%h", k, obs_addr, obs_wdata, BASE + 4 * nw, words[k-1]); end
                nw++;
            end
        end
        n_checks++; if (full !== 1'b1 || inst_count !== 3'd4) begin n_fail++; $display("FAIL b2b_full: got full=%b count=%0d want 1/4", full, inst_count); end
        n_checks++; if (nw != 4) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want 4", nw); end
        n_checks++; if (im_addr !== 32'(BASE + 16)) begin n_fail++; $display("FAIL b2b_ptr: got %h want %h", im_addr, BASE + 16); end
        tick(0, '0, 1, 0);
    endtask

    task automatic test_illegal_fmt();
        bundle_t g = mk(0, 'h33, 7, 'h20, 9, 10, 11, 0);
        tick(1, mk(6, 'h33, 0, 0, 1, 1, 1, 0), 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b0 || err !== 1'b1 || err_code !== 2'd2) begin n_fail++; $display("FAIL fmt6: got we=%b err=%b code=%0d want 0/1/2", obs_we, err, err_code); end
        tick(1, mk(1, 'h13, 0, 0, 1, 0, 0, 32'h800), 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b0 || err_code !== 2'd2) begin n_fail++; $display("FAIL fmt_sticky: got we=%b code=%0d want 0/2", obs_we, err_code); end
        tick(1, g, 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b1 || obs_addr !== 32'(BASE) || obs_wdata !== ref_word(g)) begin
            n_fail++; $display("FAIL fmt_after: got we=%b %h:%h want 1 %h:%h", obs_we, obs_addr, obs_wdata, BASE, ref_word(g)); end
        tick(0, '0, 1, 0);
    endtask

    task automatic test_clr(input bit with_rst);
        bundle_t l1 = rand_bundle(1);
        bundle_t l2 = rand_bundle(1);
        tick(1, mk(7, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        tick(1, l1, 0, 0);
        tick(1, l2, 0, 0);
        tick(0, '0, 1, with_rst);
        n_checks++; if (obs_we !== 1'b0 || obs_ready !== 1'b0) begin n_fail++; $display("FAIL clr_force[%0d]: got we=%b ready=%b want 0/0", with_rst, obs_we, obs_ready); end
        n_checks++; if (inst_count !== '0 || err !== 1'b0 || err_code !== 2'd0 || im_addr !== 32'(BASE)) begin
            n_fail++; $display("FAIL clr_state[%0d]: got cnt=%0d err=%b code=%0d addr=%h", with_rst, inst_count, err, err_code, im_addr); end
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL clr_discard[%0d]: got we=%b want 0", with_rst, obs_we); end
        tick(1, l1, 0, 0);
        tick(0, '0, 0, 0);
        n_checks++; if (obs_we !== 1'b1 || obs_addr !== 32'(BASE) || obs_wdata !== ref_word(l1)) begin
            n_fail++; $display("FAIL clr_next[%0d]: got we=%b %h:%h want 1 %h:%h", with_rst, obs_we, obs_addr, obs_wdata, BASE, ref_word(l1)); end
        tick(0, '0, 1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bit c = ($urandom_range(0, 9) == 0);
            bit r = ($urandom_range(0, 49) == 0);
            tick($urandom_range(0, 3) != 0, rand_bundle(0), c, r);
            n_checks++; if (obs_ready !== exp_ready || obs_we !== exp_we) begin
                n_fail++; $display("FAIL rnd_hs[%0d]: got ready=%b we=%b want %b/%b", k, obs_ready, obs_we, exp_ready, exp_we); end
            n_checks++; if (obs_addr !== exp_addr || obs_wdata !== exp_wdata) begin
                n_fail++; $display("FAIL rnd_port[%0d]: got %h:%h want %h:%h", k, obs_addr, obs_wdata, exp_addr, exp_wdata); end
            n_checks++; if (int'(inst_count) != m_cnt || full !== (m_cnt == DEPTH) || err !== m_err || int'(err_code) != m_code) begin
                n_fail++; $display("FAIL rnd_state[%0d]: got cnt=%0d full=%b err=%b code=%0d want %0d/%b/%b/%0d",
                                   k, inst_count, full, err, err_code, m_cnt, m_cnt == DEPTH, m_err, m_code); end
        end
    endtask

    initial begin
        @(posedge clk_im); #1;
        tick(0, '0, 0, 1);
        tick(0, '0, 0, 1);
        test_reset();
        test_r_i_type();
        test_branch_jump();
        test_back_to_back();
        test_illegal_fmt();
        test_clr(1'b0);
        test_clr(1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
